// File: rtl/pulse_sched_if.sv
// Control/status bundle for pulse_sched.
// PULSE_SCHED_LOOP_EN adds the loop control input.
interface pulse_sched_if #(parameter int unsigned W = 8);
  logic           start;
  logic           stop;
  logic [2:0]     ch_en;
  logic [3*W-1:0] high_len;
  logic [3*W-1:0] low_len;
  logic [11:0]    pulse_cnt;
`ifdef PULSE_SCHED_LOOP_EN
  logic           loop;
`endif
  logic [2:0]     p;
  logic           busy;
  logic           done;
  logic [1:0]     active_ch;

`ifdef PULSE_SCHED_LOOP_EN
  modport master (output start, stop, ch_en, high_len, low_len, pulse_cnt, loop,
                  input  p, busy, done, active_ch);
  modport slave  (input  start, stop, ch_en, high_len, low_len, pulse_cnt, loop,
                  output p, busy, done, active_ch);
`else
  modport master (output start, stop, ch_en, high_len, low_len, pulse_cnt,
                  input  p, busy, done, active_ch);
  modport slave  (input  start, stop, ch_en, high_len, low_len, pulse_cnt,
                  output p, busy, done, active_ch);
`endif
endinterface

// File: rtl/pulse_sched.sv
// Three-channel sequential pulse-burst scheduler (channels run 0, 1, 2 in order).
// Define PULSE_SCHED_LOOP_EN to add the loop input that restarts the sequence instead of finishing.
module pulse_sched #(
  parameter int unsigned W = 8
) (
  input logic          clk,
  input logic          rst_n,
  pulse_sched_if.slave bus
);

  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH0  = 3'd1,
    CH1  = 3'd2,
    CH2  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state;
  logic           phase_low;
  logic [W-1:0]   ph_cnt;
  logic [CW-1:0]  pl_cnt;
  logic [2:0]     cfg_en;
  logic [3*W-1:0] cfg_h;
  logic [3*W-1:0] cfg_l;
  logic [11:0]    cfg_cnt;

  // {found, index} of the lowest runnable channel at or above 'from'
  function automatic logic [2:0] first_run(input logic [2:0] en, input logic [11:0] cnt,
                                           input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (3'(i) >= from && en[i] && cnt[i*4 +: 4] != 4'd0) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Phase length minus one, with a programmed 0 behaving like 1
  function automatic logic [W-1:0] len_m1(input logic [W-1:0] v);
    return (v == '0) ? '0 : v - W'(1);
  endfunction

  logic           loop_c;
  logic [1:0]     cur_ch_c;
  logic [2:0]     start_sel_c;
  logic [2:0]     after_sel_c;
  logic [2:0]     restart_sel_c;
  logic [2:0]     ent_sel_c;
  logic [1:0]     ent_ch_c;
  logic [3*W-1:0] src_h_c;
  logic [11:0]    src_cnt_c;
  logic [W-1:0]   ent_h_m1_c;
  logic [CW-1:0]  ent_pl_c;
  logic [W-1:0]   cur_h_m1_c;
  logic [W-1:0]   cur_l_m1_c;
  logic           latch_c;
  logic           seq_end_c;
  logic           do_enter_c;
  logic           do_done_c;

`ifdef PULSE_SCHED_LOOP_EN
  assign loop_c = bus.loop;
`else
  assign loop_c = 1'b0;
`endif

  // Channel selection and phase reload values
  always_comb begin
    cur_ch_c = 2'd0;
    case (state)
      CH1:     cur_ch_c = 2'd1;
      CH2:     cur_ch_c = 2'd2;
      default: cur_ch_c = 2'd0;
    endcase

    start_sel_c   = first_run(bus.ch_en, bus.pulse_cnt, 3'd0);
    after_sel_c   = first_run(cfg_en, cfg_cnt, 3'(cur_ch_c) + 3'd1);
    restart_sel_c = first_run(cfg_en, cfg_cnt, 3'd0);

    if (state == IDLE) begin
      ent_sel_c = start_sel_c;
      src_h_c   = bus.high_len;
      src_cnt_c = bus.pulse_cnt;
    end else begin
      ent_sel_c = after_sel_c[2] ? after_sel_c : restart_sel_c;
      src_h_c   = cfg_h;
      src_cnt_c = cfg_cnt;
    end
    ent_ch_c   = ent_sel_c[1:0];
    ent_h_m1_c = len_m1(src_h_c[ent_ch_c*W +: W]);
    ent_pl_c   = src_cnt_c[ent_ch_c*4 +: 4] - 4'd1;
    cur_h_m1_c = len_m1(cfg_h[cur_ch_c*W +: W]);
    cur_l_m1_c = len_m1(cfg_l[cur_ch_c*W +: W]);

    latch_c    = (state == IDLE) && bus.start && !bus.stop;
    seq_end_c  = (state == CH0 || state == CH1 || state == CH2) && phase_low &&
                 (ph_cnt == '0) && (pl_cnt == '0);
    do_enter_c = (latch_c && start_sel_c[2]) ||
                 (seq_end_c && !bus.stop && (after_sel_c[2] || loop_c));
    do_done_c  = (latch_c && !start_sel_c[2]) ||
                 (seq_end_c && !bus.stop && !(after_sel_c[2] || loop_c));
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      phase_low     <= 1'b0;
      ph_cnt        <= '0;
      pl_cnt        <= '0;
      cfg_en        <= '0;
      cfg_h         <= '0;
      cfg_l         <= '0;
      cfg_cnt       <= '0;
      bus.p         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.active_ch <= 2'b11;
    end else if (state != IDLE && bus.stop) begin
      state         <= IDLE;
      phase_low     <= 1'b0;
      bus.p         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.active_ch <= 2'b11;
    end else begin
      if (latch_c) begin
        cfg_en  <= bus.ch_en;
        cfg_h   <= bus.high_len;
        cfg_l   <= bus.low_len;
        cfg_cnt <= bus.pulse_cnt;
      end
      if (do_enter_c) begin
        state         <= state_t'(3'(ent_ch_c) + 3'd1);
        phase_low     <= 1'b0;
        ph_cnt        <= ent_h_m1_c;
        pl_cnt        <= ent_pl_c;
        bus.p         <= 3'b001 << ent_ch_c;
        bus.busy      <= 1'b1;
        bus.done      <= 1'b0;
        bus.active_ch <= ent_ch_c;
      end else if (do_done_c) begin
        state         <= DONE;
        phase_low     <= 1'b0;
        bus.p         <= '0;
        bus.busy      <= 1'b0;
        bus.done      <= 1'b1;
        bus.active_ch <= 2'b11;
      end else begin
        case (state)
          CH0, CH1, CH2: begin
            if (!phase_low) begin
              if (ph_cnt == '0) begin
                phase_low <= 1'b1;
                ph_cnt    <= cur_l_m1_c;
                bus.p     <= '0;
              end else begin
                ph_cnt <= ph_cnt - W'(1);
              end
            end else if (ph_cnt != '0) begin
              ph_cnt <= ph_cnt - W'(1);
            end else begin
              // next pulse of the same channel
              pl_cnt    <= pl_cnt - 4'd1;
              phase_low <= 1'b0;
              ph_cnt    <= cur_h_m1_c;
              bus.p     <= 3'b001 << cur_ch_c;
            end
          end
          DONE: begin
            state    <= IDLE;
            bus.done <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_sched.sv
// Scoreboard bench for pulse_sched: a cycle-trace reference model feeds a queue checked by a monitor.
module tb_pulse_sched;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic [2:0] p;
    logic       busy;
    logic       done;
    logic [1:0] ac;
  } obs_t;

  localparam obs_t IDLE_O = '{p: 3'b000, busy: 1'b0, done: 1'b0, ac: 2'b11};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pulse_sched_if #(.W(W)) ifc ();
  pulse_sched #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  always #5 clk = ~clk;

  obs_t sb[$];
  obs_t trace[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic obs_t mk(input logic [2:0] pv, input logic b, input logic d,
                              input logic [1:0] a);
    obs_t o;
    o.p = pv; o.busy = b; o.done = d; o.ac = a;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Monitor: one expected observation per cycle while the scoreboard holds entries
  always @(negedge clk) begin
    obs_t e, g;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      g = {ifc.p, ifc.busy, ifc.done, ifc.active_ch};
      chk("out{p,busy,done,active_ch}", 32'(g), 32'(e));
    end
  end

  // Reference: cycle 0 = start cycle, then every high/low cycle of each runnable channel, done, idle
  task automatic build_trace(input logic [2:0] en, input logic [3*W-1:0] h,
                             input logic [3*W-1:0] l, input logic [11:0] c);
    trace.delete();
    trace.push_back(IDLE_O);
    for (int ch = 0; ch < 3; ch++) begin
      int n, hh, ll;
      n  = int'(c[ch*4 +: 4]);
      hh = int'(h[ch*W +: W]);
      ll = int'(l[ch*W +: W]);
      if (hh == 0) hh = 1;
      if (ll == 0) ll = 1;
      if (en[ch] && n > 0) begin
        for (int i = 0; i < n; i++) begin
          repeat (hh) trace.push_back(mk(3'b001 << ch, 1'b1, 1'b0, 2'(ch)));
          repeat (ll) trace.push_back(mk(3'b000, 1'b1, 1'b0, 2'(ch)));
        end
      end
    end
    trace.push_back(mk(3'b000, 1'b0, 1'b1, 2'b11));
    trace.push_back(IDLE_O);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic rand_inputs();
    ifc.ch_en     = 3'($urandom_range(0, 7));
    ifc.high_len  = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
    ifc.low_len   = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
    ifc.pulse_cnt = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
  endtask

  // stop_cyc < 0: run to completion; otherwise stop is driven during that cycle
  task automatic run_seq(input logic [2:0] en, input logic [3*W-1:0] h, input logic [3*W-1:0] l,
                         input logic [11:0] c, input int stop_cyc, input bit noise);
    build_trace(en, h, l, c);
    if (stop_cyc >= 0) begin
      while (trace.size() > stop_cyc + 1) void'(trace.pop_back());
      trace.push_back(IDLE_O);
      trace.push_back(IDLE_O);
    end
    @(posedge clk); #2;
    foreach (trace[i]) sb.push_back(trace[i]);
    ifc.start = 1'b1; ifc.stop = 1'b0;
    ifc.ch_en = en; ifc.high_len = h; ifc.low_len = l; ifc.pulse_cnt = c;
    for (int k = 1; k < trace.size(); k++) begin
      @(posedge clk); #2;
      ifc.start = noise && (trace[k].busy || trace[k].done) && ($urandom_range(0, 2) == 0);
      ifc.stop  = (k == stop_cyc);
      if (noise) rand_inputs();
    end
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    drain(50);
  endtask

  task automatic reset_mid_pulse();
    build_trace(3'b001, {8'd0, 8'd0, 8'd5}, {8'd0, 8'd0, 8'd1}, {4'd0, 4'd0, 4'd1});
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) sb.push_back(trace[i]);
    ifc.start = 1'b1;
    ifc.ch_en = 3'b001; ifc.high_len = {8'd0, 8'd0, 8'd5};
    ifc.low_len = {8'd0, 8'd0, 8'd1}; ifc.pulse_cnt = {4'd0, 4'd0, 4'd1};
    repeat (2) begin
      @(posedge clk); #2;
      ifc.start = 1'b1;
      ifc.ch_en = 3'b111;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    ifc.start = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({ifc.p, ifc.busy, ifc.done, ifc.active_ch}), 32'(IDLE_O));
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    int n_busy, sc;
    logic [2:0] en;
    logic [3*W-1:0] h, l;
    logic [11:0] c;

    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.ch_en = '0;
    ifc.high_len = '0; ifc.low_len = '0; ifc.pulse_cnt = '0;
`ifdef PULSE_SCHED_LOOP_EN
    ifc.loop = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({ifc.p, ifc.busy, ifc.done, ifc.active_ch}), 32'(IDLE_O));
    @(negedge clk);
    rst_n = 1'b1;

    // all channels, H=2 L=1 cnt=1: done in cycle 10
    run_seq(3'b111, {8'd2, 8'd2, 8'd2}, {8'd1, 8'd1, 8'd1}, {4'd1, 4'd1, 4'd1}, -1, 1'b0);
    // channel 1 only, H=3 L=2 cnt=2, inputs scrambled after start
    run_seq(3'b010, {8'd3, 8'd3, 8'd3}, {8'd2, 8'd2, 8'd2}, {4'd2, 4'd2, 4'd2}, -1, 1'b1);
    // nothing runnable: done straight after start
    run_seq(3'b000, {8'd2, 8'd2, 8'd2}, {8'd1, 8'd1, 8'd1}, {4'd1, 4'd1, 4'd1}, -1, 1'b1);
    // stop in channel 1's second high cycle, then a normal run
    run_seq(3'b111, {8'd2, 8'd2, 8'd2}, {8'd1, 8'd1, 8'd1}, {4'd1, 4'd1, 4'd1}, 5, 1'b0);
    run_seq(3'b111, {8'd2, 8'd2, 8'd2}, {8'd1, 8'd1, 8'd1}, {4'd1, 4'd1, 4'd1}, -1, 1'b0);

    // start and stop together in IDLE: nothing starts
    @(posedge clk); #2;
    repeat (3) sb.push_back(IDLE_O);
    ifc.start = 1'b1; ifc.stop = 1'b1; ifc.ch_en = 3'b111; ifc.pulse_cnt = 12'h111;
    @(posedge clk); #2;
    ifc.start = 1'b0; ifc.stop = 1'b0;
    drain(10);

    // counter boundaries: full-scale high length, zero lengths, max pulse count
    run_seq(3'b100, {8'd255, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0}, {4'd1, 4'd0, 4'd0}, -1, 1'b0);
    run_seq(3'b001, {8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0}, {4'd0, 4'd0, 4'd15}, -1, 1'b1);
    run_seq(3'b101, {8'd1, 8'd4, 8'd0}, {8'd3, 8'd0, 8'd2}, {4'd2, 4'd0, 4'd1}, -1, 1'b1);

    // async reset mid-pulse, then a start on the first edge afterwards
    reset_mid_pulse();
    run_seq(3'b011, {8'd0, 8'd1, 8'd2}, {8'd0, 8'd2, 8'd1}, {4'd0, 4'd1, 4'd2}, -1, 1'b0);

`ifdef PULSE_SCHED_LOOP_EN
    // loop: channel 0 H=1 L=1 toggles until loop drops on a low cycle
    @(posedge clk); #2;
    sb.push_back(IDLE_O);
    for (int k = 1; k <= 10; k++)
      sb.push_back(mk((k % 2 == 1) ? 3'b001 : 3'b000, 1'b1, 1'b0, 2'd0));
    sb.push_back(mk(3'b000, 1'b0, 1'b1, 2'b11));
    sb.push_back(IDLE_O);
    ifc.start = 1'b1; ifc.loop = 1'b1; ifc.ch_en = 3'b001;
    ifc.high_len = {8'd0, 8'd0, 8'd1}; ifc.low_len = {8'd0, 8'd0, 8'd1};
    ifc.pulse_cnt = {4'd0, 4'd0, 4'd1};
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #2;
      ifc.start = 1'b0;
      ifc.loop  = (k < 10);
    end
    ifc.loop = 1'b0;
    drain(20);
`endif

    // randomized sequences, some aborted by stop
    repeat (30) begin
      rand_inputs();
      en = ifc.ch_en; h = ifc.high_len; l = ifc.low_len; c = ifc.pulse_cnt;
      build_trace(en, h, l, c);
      n_busy = trace.size() - 3;
      sc = -1;
      if (n_busy >= 1 && $urandom_range(0, 3) == 0) sc = $urandom_range(1, n_busy);
      run_seq(en, h, l, c, sc, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
